// File: rtl/peak_finder_pkg.sv
// Shared types and default sizes for the filter-bank peak finder.
package peak_finder_pkg;

  localparam int SIZE_FILTER_DATA  = 16;
  localparam int TIME_W_DEFAULT    = 16;
  localparam int WIDTH_W_DEFAULT   = 8;
  localparam int HOLDOFF_DEFAULT   = 4;
  localparam int MAX_WIDTH_DEFAULT = 200;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_HOLDOFF  = 2'd3
  } peak_state_t;

  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amplitude;
    logic        [TIME_W_DEFAULT-1:0]   tstamp;
    logic        [WIDTH_W_DEFAULT-1:0]  width;
    logic                               pileup;
  } peak_event_t;

endpackage

// File: rtl/peak_finder_ts_counter.sv
// Free-running timestamp counter; wraps from all-ones back to zero.
module ts_counter
  import peak_finder_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [TIME_W-1:0] o_count
);

  logic [TIME_W-1:0] r_count;

  // Count every clock, independent of detection enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TIME_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/peak_finder.sv
// Pulse detector for one filter output stream: threshold trigger, peak and
// timestamp capture, width count with pile-up cut-off, dead time per event.
module peak_finder
  import peak_finder_pkg::*;
#(
  parameter int DATA_W    = SIZE_FILTER_DATA,
  parameter int TIME_W    = TIME_W_DEFAULT,
  parameter int WIDTH_W   = WIDTH_W_DEFAULT,
  parameter int HOLDOFF   = HOLDOFF_DEFAULT,
  parameter int MAX_WIDTH = MAX_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [DATA_W-1:0]  threshold,
  input  logic signed [DATA_W-1:0]  input_data,
  output logic                      peak_valid,
  output logic signed [DATA_W-1:0]  peak_amplitude,
  output logic        [TIME_W-1:0]  peak_time,
  output logic        [WIDTH_W-1:0] peak_width,
  output logic                      peak_pileup,
  output logic                      busy
);

  localparam int                 HC_W       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HC_W-1:0]    HOLD_LAST  = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [WIDTH_W-1:0] WIDTH_SAT  = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] PILEUP_W   = WIDTH_W'(MAX_WIDTH);
  localparam peak_state_t        POST_EVENT = (HOLDOFF > 0) ? ST_HOLDOFF : ST_IDLE;

  typedef struct packed {
    logic signed [DATA_W-1:0]  amplitude;
    logic        [TIME_W-1:0]  tstamp;
    logic        [WIDTH_W-1:0] width;
    logic                      pileup;
  } evt_t;

  function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] v);
    if (v == WIDTH_SAT) begin
      return v;
    end else begin
      return v + WIDTH_W'(1);
    end
  endfunction

  logic        [TIME_W-1:0]  w_ts;
  logic signed [DATA_W-1:0]  r_d;
  logic        [TIME_W-1:0]  r_d_ts;
  peak_state_t               r_state;
  peak_state_t               w_state_nxt;
  logic signed [DATA_W-1:0]  r_thr;
  logic signed [DATA_W-1:0]  w_thr_nxt;
  logic signed [DATA_W-1:0]  r_max;
  logic signed [DATA_W-1:0]  w_max_nxt;
  logic        [TIME_W-1:0]  r_tmax;
  logic        [TIME_W-1:0]  w_tmax_nxt;
  logic        [WIDTH_W-1:0] r_width;
  logic        [WIDTH_W-1:0] w_width_nxt;
  logic        [HC_W-1:0]    r_hold;
  logic        [HC_W-1:0]    w_hold_nxt;
  logic                      w_above;
  logic                      w_emit;
  logic                      w_pileup;
  logic                      r_emit;
  evt_t                      r_evt;

  ts_counter #(.TIME_W(TIME_W)) u_ts (
    .clk     (clk),
    .reset   (reset),
    .o_count (w_ts)
  );

  // Input register; each sample carries the timestamp of its capture edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d    <= '0;
      r_d_ts <= '0;
    end else begin
      r_d    <= input_data;
      r_d_ts <= w_ts;
    end
  end

  // FSM and pulse-tracking state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_thr   <= '0;
      r_max   <= '0;
      r_tmax  <= '0;
      r_width <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_thr   <= w_thr_nxt;
      r_max   <= w_max_nxt;
      r_tmax  <= w_tmax_nxt;
      r_width <= w_width_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state, max tracking and event decision
  always_comb begin
    w_state_nxt = r_state;
    w_thr_nxt   = r_thr;
    w_max_nxt   = r_max;
    w_tmax_nxt  = r_tmax;
    w_width_nxt = r_width;
    w_hold_nxt  = r_hold;
    w_emit      = 1'b0;
    w_pileup    = 1'b0;
    w_above     = (r_d > r_thr);
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_d > threshold) begin
            w_thr_nxt   = threshold;
            w_max_nxt   = r_d;
            w_tmax_nxt  = r_d_ts;
            w_width_nxt = WIDTH_W'(1);
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (w_above) begin
            // Strict compare keeps the earliest timestamp on a plateau
            if (r_d > r_max) begin
              w_max_nxt  = r_d;
              w_tmax_nxt = r_d_ts;
            end else begin
              w_max_nxt  = r_max;
              w_tmax_nxt = r_tmax;
            end
            w_width_nxt = sat_inc(r_width);
            if (w_width_nxt == PILEUP_W) begin
              w_emit      = 1'b1;
              w_pileup    = 1'b1;
              w_state_nxt = ST_WAIT_LOW;
            end else begin
              w_state_nxt = ST_ARMED;
            end
          end else begin
            w_emit      = 1'b1;
            w_hold_nxt  = '0;
            w_state_nxt = POST_EVENT;
          end
        end
        ST_WAIT_LOW: begin
          if (w_above) begin
            w_state_nxt = ST_WAIT_LOW;
          end else begin
            w_hold_nxt  = '0;
            w_state_nxt = POST_EVENT;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_hold_nxt  = r_hold + HC_W'(1);
            w_state_nxt = ST_HOLDOFF;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Event staging: capture the decided fields one edge before the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_emit <= 1'b0;
      r_evt  <= '0;
    end else begin
      r_emit <= w_emit;
      if (w_emit) begin
        r_evt.amplitude <= w_max_nxt;
        r_evt.tstamp    <= w_tmax_nxt;
        r_evt.width     <= w_width_nxt;
        r_evt.pileup    <= w_pileup;
      end
    end
  end

  // Registered outputs; event fields hold until the next strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_width     <= '0;
      peak_pileup    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      peak_valid <= r_emit;
      if (r_emit) begin
        peak_amplitude <= r_evt.amplitude;
        peak_time      <= r_evt.tstamp;
        peak_width     <= r_evt.width;
        peak_pileup    <= r_evt.pileup;
      end
      busy <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_peak_finder.sv
// Scoreboard bench for peak_finder: expected events are queued as stimulus is
// driven and matched against each strobe, including its arrival edge.
module tb_peak_finder;
  import peak_finder_pkg::*;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int WW = 8;
  localparam int SW = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic                 en_wrap = 1'b0;
  logic signed [DW-1:0] threshold = 16'sd0;
  logic signed [DW-1:0] input_data = 16'sd0;

  logic                 peak_valid;
  logic signed [DW-1:0] peak_amplitude;
  logic [TW-1:0]        peak_time;
  logic [WW-1:0]        peak_width;
  logic                 peak_pileup;
  logic                 busy;

  logic                 w_valid;
  logic signed [DW-1:0] w_amp;
  logic [SW-1:0]        w_time;
  logic [WW-1:0]        w_width;
  logic                 w_pileup;
  logic                 w_busy;

  typedef struct {
    logic signed [DW-1:0] amp;
    logic [TW-1:0]        ts;
    logic [WW-1:0]        width;
    logic                 pileup;
    int                   edge_no;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [TW-1:0] m_ts;
  logic [TW-1:0] d_ts;
  logic [TW-1:0] t_pk;
  int            d_e;
  int            e_tm;
  int            k;

  always #5 clk = ~clk;

  peak_finder #(.DATA_W(DW), .TIME_W(TW), .WIDTH_W(WW), .HOLDOFF(4), .MAX_WIDTH(5)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .input_data(input_data),
    .peak_valid(peak_valid), .peak_amplitude(peak_amplitude), .peak_time(peak_time),
    .peak_width(peak_width), .peak_pileup(peak_pileup), .busy(busy)
  );

  peak_finder #(.DATA_W(DW), .TIME_W(SW), .WIDTH_W(WW), .HOLDOFF(4), .MAX_WIDTH(200)) u_wrap (
    .clk(clk), .reset(reset), .enable(en_wrap), .threshold(threshold), .input_data(input_data),
    .peak_valid(w_valid), .peak_amplitude(w_amp), .peak_time(w_time),
    .peak_width(w_width), .peak_pileup(w_pileup), .busy(w_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference timestamp: value present at each capture edge
  always @(posedge clk or posedge reset) begin
    if (reset) m_ts <= '0;
    else       m_ts <= m_ts + 16'd1;
  end

  // Scoreboard monitor on the falling edge
  always @(negedge clk) begin
    if (!reset && peak_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_strobe: peak_valid=1 after edge %0d amp=%0d, required no event", cyc, peak_amplitude);
      end else begin
        mon_e = sb_q.pop_front();
        n_cmp++;
        if (cyc !== mon_e.edge_no) begin n_err++; $display("FAIL evt_latency: strobe after edge %0d, required %0d", cyc, mon_e.edge_no); end
        n_cmp++;
        if (peak_amplitude !== mon_e.amp) begin n_err++; $display("FAIL evt_amplitude: got %0d, required %0d", peak_amplitude, mon_e.amp); end
        n_cmp++;
        if (peak_time !== mon_e.ts) begin n_err++; $display("FAIL evt_time: got %0d, required %0d", peak_time, mon_e.ts); end
        n_cmp++;
        if (peak_width !== mon_e.width) begin n_err++; $display("FAIL evt_width: got %0d, required %0d", peak_width, mon_e.width); end
        n_cmp++;
        if (peak_pileup !== mon_e.pileup) begin n_err++; $display("FAIL evt_pileup: got %0b, required %0b", peak_pileup, mon_e.pileup); end
      end
    end
  end

  task automatic send(input logic signed [DW-1:0] v, output logic [TW-1:0] ts, output int eno);
    @(negedge clk);
    input_data = v;
    ts  = m_ts;
    eno = cyc + 1;
  endtask

  task automatic idle(input logic signed [DW-1:0] v, input int n);
    for (int i = 0; i < n; i++) send(v, d_ts, d_e);
  endtask

  task automatic drain(input string name, input int budget);
    int j;
    j = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && j < budget) begin
      @(negedge clk);
      j++;
    end
    n_cmp++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: %0d events outstanding, busy=%0b after %0d cycles, required 0 and 0", name, sb_q.size(), busy, j);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (peak_valid !== 1'b0)      begin n_err++; $display("FAIL reset_valid: got %0b, required 0", peak_valid); end
    n_cmp++; if (peak_amplitude !== 16'sd0) begin n_err++; $display("FAIL reset_amp: got %0d, required 0", peak_amplitude); end
    n_cmp++; if (peak_time !== 16'd0)      begin n_err++; $display("FAIL reset_time: got %0d, required 0", peak_time); end
    n_cmp++; if (peak_width !== 8'd0)      begin n_err++; $display("FAIL reset_width: got %0d, required 0", peak_width); end
    n_cmp++; if (peak_pileup !== 1'b0)     begin n_err++; $display("FAIL reset_pileup: got %0b, required 0", peak_pileup); end
    n_cmp++; if (busy !== 1'b0)            begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    reset = 1'b0;
    enable = 1'b1;
    threshold = 16'sd100;
    idle(16'sd0, 3);
  endtask

  task automatic test_basic();
    idle(16'sd0, 1);
    send(16'sd50, d_ts, d_e);
    send(16'sd150, d_ts, d_e);
    send(16'sd300, t_pk, d_e);
    send(16'sd250, d_ts, d_e);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0b, required 1", busy); end
    send(16'sd90, d_ts, e_tm);
    sb_q.push_back('{16'sd300, t_pk, 8'd3, 1'b0, e_tm + 2});
    idle(16'sd0, 1);
    drain("basic", 20);
    n_cmp++; if (peak_valid !== 1'b0 || peak_amplitude !== 16'sd300) begin
      n_err++; $display("FAIL basic_hold: valid=%0b amp=%0d, required 0 and 300", peak_valid, peak_amplitude);
    end
  endtask

  task automatic test_plateau();
    idle(16'sd0, 3);
    send(16'sd200, t_pk, d_e);
    send(16'sd200, d_ts, d_e);
    send(16'sd200, d_ts, d_e);
    send(16'sd50, d_ts, e_tm);
    sb_q.push_back('{16'sd200, t_pk, 8'd3, 1'b0, e_tm + 2});
    idle(16'sd0, 1);
    drain("plateau", 20);
  endtask

  task automatic test_pileup();
    threshold = 16'sd10;
    idle(16'sd0, 2);
    send(16'sd500, t_pk, d_e);
    for (int i = 1; i < 20; i++) begin
      send(16'sd500, d_ts, d_e);
      if (i == 4) sb_q.push_back('{16'sd500, t_pk, 8'd5, 1'b1, d_e + 2});
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pileup_waitlow_busy: got %0b, required 1", busy); end
    idle(16'sd0, 1);
    drain("pileup", 20);
    threshold = 16'sd100;
    idle(16'sd0, 2);
  endtask

  task automatic test_holdoff();
    send(16'sd300, t_pk, d_e);
    send(16'sd0, d_ts, e_tm);
    sb_q.push_back('{16'sd300, t_pk, 8'd1, 1'b0, e_tm + 2});
    idle(16'sd0, 3);
    send(16'sd300, d_ts, d_e);
    idle(16'sd0, 3);
    send(16'sd300, t_pk, d_e);
    send(16'sd0, d_ts, e_tm);
    sb_q.push_back('{16'sd300, t_pk, 8'd1, 1'b0, e_tm + 2});
    drain("holdoff", 20);
  endtask

  task automatic test_enable_drop();
    idle(16'sd0, 2);
    send(16'sd300, d_ts, d_e);
    send(16'sd400, d_ts, d_e);
    send(16'sd350, d_ts, d_e);
    enable = 1'b0;
    send(16'sd350, d_ts, d_e);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL enable_drop_busy: got %0b, required 0", busy); end
    idle(16'sd0, 2);
    enable = 1'b1;
    idle(16'sd0, 6);
    drain("enable_drop", 10);
  endtask

  task automatic test_reset_mid();
    send(16'sd300, d_ts, d_e);
    send(16'sd400, d_ts, d_e);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (peak_valid !== 1'b0 || peak_amplitude !== 16'sd0 || peak_width !== 8'd0) begin
      n_err++; $display("FAIL reset_mid_outputs: valid=%0b amp=%0d width=%0d, required all 0", peak_valid, peak_amplitude, peak_width);
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy: got %0b, required 0", busy); end
    input_data = 16'sd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(16'sd0, 2);
    send(16'sd150, t_pk, d_e);
    send(16'sd0, d_ts, e_tm);
    sb_q.push_back('{16'sd150, t_pk, 8'd1, 1'b0, e_tm + 2});
    drain("reset_mid", 20);
  endtask

  task automatic test_negative();
    idle(-16'sd100, 2);
    threshold = -16'sd50;
    idle(-16'sd100, 1);
    send(-16'sd20, t_pk, d_e);
    send(-16'sd60, d_ts, e_tm);
    sb_q.push_back('{-16'sd20, t_pk, 8'd1, 1'b0, e_tm + 2});
    drain("negative", 20);
    idle(-16'sd100, 1);
    threshold = 16'sd100;
    idle(16'sd0, 2);
  endtask

  task automatic test_wrap();
    enable = 1'b0;
    en_wrap = 1'b1;
    k = 0;
    @(negedge clk);
    while (m_ts[7:0] != 8'hFC && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (m_ts[7:0] != 8'hFC) begin n_err++; $display("FAIL wrap_align: ts=%0d, required 252", m_ts[7:0]); end
    send(16'sd150, d_ts, d_e);
    send(16'sd200, d_ts, d_e);
    send(16'sd300, d_ts, d_e);
    send(16'sd250, d_ts, d_e);
    send(16'sd0, d_ts, e_tm);
    k = 0;
    while (w_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (w_valid !== 1'b1) begin n_err++; $display("FAIL wrap_strobe: none within %0d cycles, required one", k); end
    n_cmp++; if (cyc !== e_tm + 2) begin n_err++; $display("FAIL wrap_latency: strobe after edge %0d, required %0d", cyc, e_tm + 2); end
    n_cmp++; if (w_time !== 8'hFF) begin n_err++; $display("FAIL wrap_time: got %0d, required 255", w_time); end
    n_cmp++; if (w_amp !== 16'sd300) begin n_err++; $display("FAIL wrap_amp: got %0d, required 300", w_amp); end
    n_cmp++; if (w_width !== 8'd4 || w_pileup !== 1'b0) begin n_err++; $display("FAIL wrap_width: width=%0d pileup=%0b, required 4 and 0", w_width, w_pileup); end
    idle(16'sd0, 8);
    n_cmp++; if (w_busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy: got %0b, required 0", w_busy); end
    en_wrap = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_plateau();
    test_pileup();
    test_holdoff();
    test_enable_drop();
    test_reset_mid();
    test_negative();
    test_wrap();
    idle(16'sd0, 4);
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL final_queue: %0d outstanding, required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/peak_finder.md
Name: peak_finder

Overview:
- Downstream stage of the filter bank. Consumes one filter output stream (output_data_vN, SIZE_FILTER_DATA bits, two's complement), finds pulses above a programmable threshold, and reports one event per pulse.
- Event fields: peak amplitude, timestamp of the peak sample, pulse width, pile-up flag.
- One instance is placed per filter variant under comparison, beside the filter instances in the filter top level.

Parameters:
- DATA_W, SIZE_FILTER_DATA, width of input sample and amplitude (signed).
- TIME_W, 16, width of free-running timestamp counter.
- WIDTH_W, 8, width of pulse-width counter.
- HOLDOFF, 4, dead-time cycles after each event (0 allowed).
- MAX_WIDTH, 200, pulse length at which pile-up is declared (< 2**WIDTH_W).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  detection enable
- threshold  in  DATA_W  signed trigger level
- input_data  in  DATA_W  signed filter output, one sample per clk
- peak_valid  out  1  one-cycle event strobe
- peak_amplitude  out  DATA_W  maximum sample of pulse
- peak_time  out  TIME_W  timestamp of maximum sample
- peak_width  out  WIDTH_W  samples above threshold (saturating)
- peak_pileup  out  1  pulse reached MAX_WIDTH
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous, active-high: all outputs 0, FSM in IDLE, timestamp counter 0, input register 0.
- Input pipeline: input_data is registered into d_reg every edge. d_reg carries the timestamp value present at its capture edge. The FSM acts on d_reg.
- Timestamp counter: +1 every clock regardless of enable. Wraps 2**TIME_W-1 -> 0. A wrapped timestamp is reported as is.
- All comparisons are signed. "Above" means d_reg > thr, strictly.
- IDLE state:
  - If enable=1 and d_reg > threshold: latch thr := threshold, max := d_reg, tmax := d_ts, width := 1, go to ARMED.
  - threshold is sampled only at this transition. Later changes do not affect the current pulse.
- ARMED state:
  - If d_reg > max (strictly): max := d_reg, tmax := d_ts. On a tie the earliest sample's time is kept.
  - width increments and saturates at 2**WIDTH_W-1.
  - If d_reg <= thr: emit event, go to HOLDOFF (or IDLE if HOLDOFF=0). The terminating sample is not counted in width.
  - If width reaches MAX_WIDTH while still above thr: emit event with peak_pileup=1, go to WAIT_LOW.
- WAIT_LOW state: stay until d_reg <= thr, then go to HOLDOFF (or IDLE). No event is emitted.
- HOLDOFF state: count HOLDOFF cycles, then go to IDLE. Above-threshold samples are ignored, with no event and no retrigger within the same cycle as the exit.
- Emit: on the edge after the FSM decision, peak_valid=1 for exactly one cycle with all fields updated. Fields hold their value until the next event.
- Latency: peak_valid rises 2 edges after the edge that sampled the first input <= thr.
- enable=0 in any state: next edge goes to IDLE, the pending pulse is discarded, no strobe. The counter keeps running.
- busy = (state != IDLE), registered.

Decomposition:
- Add to package_settings: TIME_W/WIDTH_W defaults, typedef peak_event_t (amplitude, time, width, pileup), and enum peak_state_t {IDLE, ARMED, WAIT_LOW, HOLDOFF}.
- One sub-module: ts_counter (free-running wrap counter, TIME_W).
- FSM and max tracking stay in peak_finder.

Test Plan:
- threshold=100, HOLDOFF=4. Input 0,50,150,300,250,90,0 with the 300 sample timestamped t. Expect peak_valid one cycle, amplitude=300, time=t, width=3, pileup=0, strobe 2 edges after sampling 90.
- Plateau 0,200,200,200,50. Expect amplitude=200, time equal to the first 200's timestamp, width=3.
- threshold=10, MAX_WIDTH=5, input held at 500 for 20 cycles then 0. Expect one event: width=5, pileup=1, then no further strobe until the input falls and HOLDOFF expires.
- Second pulse arriving 2 cycles after the first event (HOLDOFF=4). Expect it ignored, no second strobe. The same pulse arriving 6 cycles after: second event reported.
- enable dropped mid-pulse, or reset asserted mid-pulse. Expect no strobe. Reset: outputs immediately 0 asynchronously, busy=0; the next pulse after release is detected normally.
- Negative values: threshold=-50, input -100,-20,-60. Expect amplitude=-20, width=1. Counter wrap: pulse peaking at timestamp 65535 then 0 (TIME_W=16). Expect time=65535.
